// File: rtl/dmem_readback.sv
// dmem_readback: walks a word-aligned data-memory range through a synchronous read port
// and streams the words out of a 2-entry FIFO over a valid/ready handshake.
module dmem_readback #(
  parameter int CNT_W    = 16,
  parameter int ADR_STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             Ext_MemRead,
  output logic [31:0]      Ext_ReadAdr,
  input  logic [31:0]      Ext_ReadData,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_index,
  input  logic             out_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] base, t_data;
  logic [CNT_W-1:0] count, issued, infl_idx, t_idx;
  logic [1:0] occ;
  logic infl, zdone, pop, accept, kill, drained;
  assign accept      = state == IDLE && start && word_count != '0;
  assign kill        = state != IDLE && abort;
  assign pop         = out_valid && out_ready;
  assign out_valid   = occ != 2'd0;
  assign busy        = state != IDLE;
  assign drained     = !infl && occ == 2'd0;
  assign done        = zdone || (state == DRAIN && drained && !abort);
  // a read may reuse the slot being popped this very cycle, so the FIFO never overflows
  assign Ext_MemRead = state == RUN && (occ == 2'd0 || (occ == 2'd1 && !infl) || pop);
  assign Ext_ReadAdr = base + 32'(ADR_STEP) * 32'(issued);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? RUN : IDLE;
      RUN:     state_n = abort ? IDLE : (Ext_MemRead && issued == count - 1'b1) ? DRAIN : RUN;
      DRAIN:   state_n = (abort || drained) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      base      <= '0;
      count     <= '0;
      issued    <= '0;
      infl      <= 1'b0;
      infl_idx  <= '0;
      zdone     <= 1'b0;
      occ       <= '0;
      out_data  <= '0;
      out_index <= '0;
      t_data    <= '0;
      t_idx     <= '0;
    end else begin
      state <= state_n;
      zdone <= state == IDLE && start && word_count == '0;
      infl  <= Ext_MemRead && !kill;
      if (accept) begin
        base   <= base_adr;
        count  <= word_count;
        issued <= '0;
      end else if (Ext_MemRead) issued <= issued + 1'b1;
      if (Ext_MemRead) infl_idx <= issued;
      if (kill) occ <= '0;
      else begin
        occ <= occ + {1'b0, infl} - {1'b0, pop};
        if (infl && (occ == 2'd0 || (pop && occ == 2'd1))) {out_data, out_index} <= {Ext_ReadData, infl_idx};
        else if (pop) {out_data, out_index} <= {t_data, t_idx};
        if (infl && (occ == 2'd2 || (occ == 2'd1 && !pop))) {t_data, t_idx} <= {Ext_ReadData, infl_idx};
      end
    end
endmodule
